// File: rtl/e_gpu.sv
// rtl/e_gpu.sv - shared GPU-side types used by the cache response gather block
package e_gpu;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } gather_state_e;

endpackage

// File: rtl/vx_cache_rsp_lane_capture.sv
// rtl/vx_cache_rsp_lane_capture.sv - one response lane: tag-qualified accept, data capture, received bit
module vx_cache_rsp_lane_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  collect_en,
  input  logic                  expected,
  input  logic [TAG_WIDTH-1:0]  lat_tag,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_ready,
  output logic                  fire,
  output logic                  received,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  received_q, received_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Anything not wanted right now is held off rather than dropped or overwritten.
  assign rsp_ready = collect_en & expected & ~received_q & (rsp_tag == lat_tag);
  assign fire      = rsp_valid & rsp_ready;

  always_comb begin
    received_d = received_q;
    data_d     = data_q;
    if (clr) begin
      received_d = 1'b0;
      data_d     = '0;
    end else if (fire) begin
      received_d = 1'b1;
      data_d     = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      received_q <= 1'b0;
      data_q     <= '0;
    end else begin
      received_q <= received_d;
      data_q     <= data_d;
    end
  end

  assign received = received_q;
  assign data     = data_q;

endmodule

// File: rtl/vx_cache_rsp_gather.sv
// rtl/vx_cache_rsp_gather.sv - gathers per-lane cache responses carrying one tag into a single merged response
module vx_cache_rsp_gather
  import e_gpu::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [TAG_WIDTH-1:0]           start_tag,
  input  logic [NUM_REQS-1:0]            start_mask,
  input  logic [NUM_REQS-1:0]            rsp_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag,
  output logic [NUM_REQS-1:0]            rsp_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_REQS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQS-1:0]            out_mask,
  output logic [TAG_WIDTH-1:0]           out_tag
);

  gather_state_e          state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [NUM_REQS-1:0]    expected_q, expected_d;
  logic                   out_valid_q, out_valid_d;
  logic                   clr_lanes;
  logic                   collect_en;
  logic [NUM_REQS-1:0]    fired;
  logic [NUM_REQS-1:0]    received;

  // Gated by reset so both handshakes read low for the whole reset window.
  assign start_ready = (state_q == IDLE) & ~reset;
  assign collect_en  = (state_q == COLLECT) & ~reset;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    vx_cache_rsp_lane_capture #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_lanes),
      .collect_en(collect_en),
      .expected  (expected_q[i]),
      .lat_tag   (tag_q),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rsp_tag   (rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .rsp_ready (rsp_ready[i]),
      .fire      (fired[i]),
      .received  (received[i]),
      .data      (out_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    expected_d = expected_q;
    clr_lanes  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          tag_d      = start_tag;
          expected_d = start_mask;
          clr_lanes  = 1'b1;
          state_d    = (start_mask == '0) ? OUTPUT : COLLECT;
        end
      end
      COLLECT: begin
        if ((received | fired) == expected_q) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      expected_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      expected_q  <= expected_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = expected_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_vx_cache_rsp_gather.sv
// tb/tb_vx_cache_rsp_gather.sv - directed scoreboard bench for vx_cache_rsp_gather
module tb_vx_cache_rsp_gather;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [7:0]   start_tag;
  logic [3:0]   start_mask;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic [31:0]  rsp_tag;
  logic [3:0]   rsp_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_mask;
  logic [7:0]   out_tag;

  typedef struct {
    logic [7:0]   tag;
    logic [3:0]   mask;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  vx_cache_rsp_gather dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .start_tag  (start_tag),
    .start_mask (start_mask),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_gather(input logic [7:0] tag, input logic [3:0] mask, input logic [127:0] data);
    exp_t e;
    e.tag  = tag;
    e.mask = mask;
    e.data = data;
    sb.push_back(e);
    start_valid = 1'b1;
    start_tag   = tag;
    start_mask  = mask;
    #1;
    chk("start_ready_idle", {127'b0, start_ready}, 128'd1);
    step();
    start_valid = 1'b0;
    chk("start_ready_busy", {127'b0, start_ready}, 128'd0);
  endtask

  task automatic expect_out(input int budget);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("out_valid_wait", {127'b0, out_valid}, 128'd1);
    chk("sb_nonempty", {127'b0, (sb.size() > 0)}, 128'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_tag", {120'b0, out_tag}, {120'b0, e.tag});
      chk("out_mask", {124'b0, out_mask}, {124'b0, e.mask});
      chk("out_data", out_data, e.data);
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", {127'b0, out_valid}, 128'd0);
    chk("start_ready_after_hs", {127'b0, start_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] snap;
    reset       = 1'b1;
    start_valid = 1'b0;
    start_tag   = '0;
    start_mask  = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_tag     = '0;
    out_ready   = 1'b0;
    step();
    step();
    chk("rst_start_ready", {127'b0, start_ready}, 128'd0);
    chk("rst_rsp_ready", {124'b0, rsp_ready}, 128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_mask", {124'b0, out_mask}, 128'd0);
    chk("rst_out_tag", {120'b0, out_tag}, 128'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_start_ready", {127'b0, start_ready}, 128'd1);

    // All four lanes respond together
    start_gather(8'h12, 4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    rsp_tag   = {4{8'h12}};
    rsp_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rsp_valid = 4'b1111;
    #1;
    chk("t1_rsp_ready", {124'b0, rsp_ready}, {124'b0, 4'b1111});
    step();
    rsp_valid = '0;
    expect_out(0);
    step();
    chk("t1_hold_valid", {127'b0, out_valid}, 128'd1);
    chk("t1_hold_data", out_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    finish_out();

    // Sparse mask; unexpected lanes 1,3 keep pushing, lane 2 retries after capture
    start_gather(8'h05, 4'b0101, {32'h0, 32'hC2, 32'h0, 32'hC0});
    rsp_tag = {4{8'h05}};
    for (int c = 1; c <= 7; c++) begin
      rsp_valid = {1'b1, (c >= 3), 1'b1, (c == 7)};
      rsp_data  = {32'hFF3, (c == 3) ? 32'hC2 : 32'hEE, 32'hFF1, 32'hC0};
      #1;
      chk("t2_ready_lane1", {127'b0, rsp_ready[1]}, 128'd0);
      chk("t2_ready_lane3", {127'b0, rsp_ready[3]}, 128'd0);
      chk("t2_no_early_valid", {127'b0, out_valid}, 128'd0);
      step();
    end
    rsp_valid = '0;
    expect_out(0);
    finish_out();

    // Wrong tag on lane 0 is held off, then the right tag completes
    start_gather(8'h05, 4'b0001, {96'h0, 32'h55});
    rsp_valid = 4'b0001;
    rsp_tag   = {24'h0, 8'h06};
    rsp_data  = {96'h0, 32'h66};
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_bad_tag_ready", {124'b0, rsp_ready}, 128'd0);
      step();
      chk("t3_no_capture", {127'b0, out_valid}, 128'd0);
    end
    rsp_tag  = {24'h0, 8'h05};
    rsp_data = {96'h0, 32'h55};
    #1;
    chk("t3_good_tag_ready", {124'b0, rsp_ready}, {124'b0, 4'b0001});
    step();
    rsp_valid = '0;
    expect_out(0);
    finish_out();

    // Empty mask goes straight to output and holds under back-pressure
    start_gather(8'h77, 4'b0000, 128'h0);
    for (int c = 0; c < 5; c++) begin
      chk("t4_valid_hold", {127'b0, out_valid}, 128'd1);
      chk("t4_mask_zero", {124'b0, out_mask}, 128'd0);
      chk("t4_data_zero", out_data, 128'd0);
      chk("t4_start_ready", {127'b0, start_ready}, 128'd0);
      step();
    end
    expect_out(0);
    finish_out();

    // Reset in the middle of a gather, then a clean one
    start_gather(8'h21, 4'b1111, 128'h0);
    rsp_tag   = {4{8'h21}};
    rsp_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    rsp_valid = 4'b0011;
    step();
    rsp_valid = '0;
    #1;
    chk("t5_partial_ready", {124'b0, rsp_ready}, {124'b0, 4'b1100});
    reset = 1'b1;
    step();
    chk("t5_rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("t5_rst_out_data", out_data, 128'd0);
    chk("t5_rst_out_mask", {124'b0, out_mask}, 128'd0);
    chk("t5_rst_out_tag", {120'b0, out_tag}, 128'd0);
    chk("t5_rst_start_ready", {127'b0, start_ready}, 128'd0);
    chk("t5_rst_rsp_ready", {124'b0, rsp_ready}, 128'd0);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("t5_idle_after_rst", {127'b0, start_ready}, 128'd1);
    start_gather(8'h33, 4'b1111, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    rsp_tag  = {4{8'h33}};
    rsp_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    rsp_valid = 4'b1001;
    step();
    rsp_valid = 4'b0110;
    step();
    rsp_valid = '0;
    expect_out(4);
    snap = out_data;
    out_ready = 1'b0;
    step();
    chk("t5_stable_data", out_data, snap);
    finish_out();

    chk("sb_drained", sb.size(), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
